// File: rtl/rename_pkg.sv
// Shared types for the rename/retire slice: register and tag widths plus the
// reorder-buffer entry layout.
package rename_pkg;

    localparam int NUM_P_REGS = 64;
    localparam int NUM_A_REGS = 32;
    localparam int ROB_DEPTH  = 16;

    localparam int P = $clog2(NUM_P_REGS);
    localparam int A = $clog2(NUM_A_REGS);
    localparam int T = $clog2(ROB_DEPTH);

    typedef logic [P-1:0] p_reg_t;
    typedef logic [A-1:0] a_reg_t;
    typedef logic [T-1:0] rob_tag_t;

    typedef struct packed {
        logic   valid;
        logic   done;
        logic   has_dest;
        a_reg_t a_dest;
        p_reg_t p_dest;
        p_reg_t old_dest;
    } rob_entry_t;

    localparam p_reg_t PREG_ZERO = '0;

endpackage

// File: rtl/rob_entry_array.sv
// Reorder-buffer entry storage: two allocate write ports, two done-set ports,
// two retire-clear ports and two read ports for head and head+1.
module rob_entry_array
    import rename_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       we0_i,
    input  rob_tag_t   waddr0_i,
    input  rob_entry_t wdata0_i,
    input  logic       we1_i,
    input  rob_tag_t   waddr1_i,
    input  rob_entry_t wdata1_i,
    input  logic       set0_i,
    input  rob_tag_t   set_tag0_i,
    input  logic       set1_i,
    input  rob_tag_t   set_tag1_i,
    input  logic       clr0_i,
    input  rob_tag_t   clr_tag0_i,
    input  logic       clr1_i,
    input  rob_tag_t   clr_tag1_i,
    input  rob_tag_t   rd_tag0_i,
    output rob_entry_t rd0_o,
    input  rob_tag_t   rd_tag1_i,
    output rob_entry_t rd1_o
);

    rob_entry_t mem_q [ROB_DEPTH];

    assign rd0_o = mem_q[rd_tag0_i];
    assign rd1_o = mem_q[rd_tag1_i];

    // Later statements win: a slot cleared on retire is never written the same
    // cycle (stall uses the pre-edge count), and a freshly written slot must
    // start not-done, so done-set goes first and allocate last.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (set0_i && mem_q[set_tag0_i].valid) mem_q[set_tag0_i].done <= 1'b1;
            if (set1_i && mem_q[set_tag1_i].valid) mem_q[set_tag1_i].done <= 1'b1;
            if (clr0_i) begin
                mem_q[clr_tag0_i].valid <= 1'b0;
                mem_q[clr_tag0_i].done  <= 1'b0;
            end
            if (clr1_i) begin
                mem_q[clr_tag1_i].valid <= 1'b0;
                mem_q[clr_tag1_i].done  <= 1'b0;
            end
            if (we0_i) mem_q[waddr0_i] <= wdata0_i;
            if (we1_i) mem_q[waddr1_i] <= wdata1_i;
        end
    end

endmodule

// File: rtl/rob_retire_unit.sv
// Two-wide in-order reorder buffer: allocates renamed instructions, marks them
// complete by tag and retires up to two per cycle, freeing superseded registers.
module rob_retire_unit
    import rename_pkg::*;
#(
    parameter int NUM_P_REGS = rename_pkg::NUM_P_REGS,
    parameter int NUM_A_REGS = rename_pkg::NUM_A_REGS,
    parameter int ROB_DEPTH  = rename_pkg::ROB_DEPTH,
    localparam int P = $clog2(NUM_P_REGS),
    localparam int A = $clog2(NUM_A_REGS),
    localparam int T = $clog2(ROB_DEPTH)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         alloc0_i,
    input  logic         alloc1_i,
    input  logic         has_dest0_i,
    input  logic         has_dest1_i,
    input  logic [A-1:0] a_dest0_i,
    input  logic [A-1:0] a_dest1_i,
    input  logic [P-1:0] p_dest0_i,
    input  logic [P-1:0] p_dest1_i,
    input  logic [P-1:0] old_dest0_i,
    input  logic [P-1:0] old_dest1_i,
    output logic [T-1:0] rob_tag0_o,
    output logic [T-1:0] rob_tag1_o,
    output logic         rob_stall_o,
    input  logic         cmpl0_en_i,
    input  logic         cmpl1_en_i,
    input  logic [T-1:0] cmpl0_tag_i,
    input  logic [T-1:0] cmpl1_tag_i,
    output logic         en_free_reg0_o,
    output logic         en_free_reg1_o,
    output logic [P-1:0] free_reg0_o,
    output logic [P-1:0] free_reg1_o,
    output logic [1:0]   retire_cnt_o,
    output logic         rob_empty_o,
    output logic [T:0]   rob_count_o
);

    localparam logic [T:0] DEPTH_W = (T+1)'(ROB_DEPTH);

    logic [T-1:0] head_q, head_d, tail_q, tail_d, head_p1;
    logic [T:0]   count_q, count_d, free_slots;

    logic         en_free0_q, en_free0_d, en_free1_q, en_free1_d;
    logic [P-1:0] free0_q, free0_d, free1_q, free1_d;
    logic [1:0]   ret_cnt_q, ret_cnt_d;

    logic         alloc_ok, alloc_two, ret0, ret1;
    logic [1:0]   n_alloc;
    rob_entry_t   wdata0, wdata1, head_e, next_e;

    assign head_p1    = head_q + 1'b1;
    assign free_slots = DEPTH_W - count_q;

    assign rob_tag0_o  = tail_q;
    assign rob_tag1_o  = tail_q + 1'b1;
    assign rob_stall_o = free_slots < (T+1)'(2);
    assign rob_empty_o = (count_q == '0);
    assign rob_count_o = count_q;

    // Stall is all-or-nothing, so a pair is never half accepted.
    assign alloc_ok  = alloc0_i & ~rob_stall_o;
    assign alloc_two = alloc_ok & alloc1_i;
    assign n_alloc   = alloc_two ? 2'd2 : (alloc_ok ? 2'd1 : 2'd0);

    assign wdata0 = '{valid: 1'b1, done: 1'b0, has_dest: has_dest0_i,
                      a_dest: a_dest0_i, p_dest: p_dest0_i, old_dest: old_dest0_i};
    assign wdata1 = '{valid: 1'b1, done: 1'b0, has_dest: has_dest1_i,
                      a_dest: a_dest1_i, p_dest: p_dest1_i, old_dest: old_dest1_i};

    assign ret0 = head_e.valid & head_e.done;
    assign ret1 = ret0 & next_e.valid & next_e.done;

    rob_entry_array u_entries (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .we0_i      (alloc_ok),
        .waddr0_i   (tail_q),
        .wdata0_i   (wdata0),
        .we1_i      (alloc_two),
        .waddr1_i   (rob_tag1_o),
        .wdata1_i   (wdata1),
        .set0_i     (cmpl0_en_i),
        .set_tag0_i (cmpl0_tag_i),
        .set1_i     (cmpl1_en_i),
        .set_tag1_i (cmpl1_tag_i),
        .clr0_i     (ret0),
        .clr_tag0_i (head_q),
        .clr1_i     (ret1),
        .clr_tag1_i (head_p1),
        .rd_tag0_i  (head_q),
        .rd0_o      (head_e),
        .rd_tag1_i  (head_p1),
        .rd1_o      (next_e)
    );

    always_comb begin
        ret_cnt_d  = ret1 ? 2'd2 : (ret0 ? 2'd1 : 2'd0);
        head_d     = head_q + T'(ret_cnt_d);
        tail_d     = tail_q + T'(n_alloc);
        count_d    = count_q + (T+1)'(n_alloc) - (T+1)'(ret_cnt_d);
        // Physical register zero is the hardwired mapping and never recycled.
        en_free0_d = ret0 & head_e.has_dest & (head_e.old_dest != PREG_ZERO);
        en_free1_d = ret1 & next_e.has_dest & (next_e.old_dest != PREG_ZERO);
        free0_d    = en_free0_d ? head_e.old_dest : '0;
        free1_d    = en_free1_d ? next_e.old_dest : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            en_free0_q <= 1'b0;
            en_free1_q <= 1'b0;
            free0_q    <= '0;
            free1_q    <= '0;
            ret_cnt_q  <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            en_free0_q <= en_free0_d;
            en_free1_q <= en_free1_d;
            free0_q    <= free0_d;
            free1_q    <= free1_d;
            ret_cnt_q  <= ret_cnt_d;
        end
    end

    assign en_free_reg0_o = en_free0_q;
    assign en_free_reg1_o = en_free1_q;
    assign free_reg0_o    = free0_q;
    assign free_reg1_o    = free1_q;
    assign retire_cnt_o   = ret_cnt_q;

endmodule

// File: tb/tb_rob_retire_unit.sv
// Directed bench for rob_retire_unit: expected retire/free beats are queued
// when completions are issued and checked by an independent monitor.
module tb_rob_retire_unit;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       alloc0_i = 0, alloc1_i = 0, has_dest0_i = 0, has_dest1_i = 0;
    logic [4:0] a_dest0_i = '0, a_dest1_i = '0;
    logic [5:0] p_dest0_i = '0, p_dest1_i = '0, old_dest0_i = '0, old_dest1_i = '0;
    logic [3:0] rob_tag0_o, rob_tag1_o;
    logic       rob_stall_o;
    logic       cmpl0_en_i = 0, cmpl1_en_i = 0;
    logic [3:0] cmpl0_tag_i = '0, cmpl1_tag_i = '0;
    logic       en_free_reg0_o, en_free_reg1_o;
    logic [5:0] free_reg0_o, free_reg1_o;
    logic [1:0] retire_cnt_o;
    logic       rob_empty_o;
    logic [4:0] rob_count_o;

    // Beat layout: {retire_cnt, en0, free0, en1, free1}
    localparam int W = 16;
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    rob_retire_unit dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alloc0_i(alloc0_i), .alloc1_i(alloc1_i),
        .has_dest0_i(has_dest0_i), .has_dest1_i(has_dest1_i),
        .a_dest0_i(a_dest0_i), .a_dest1_i(a_dest1_i),
        .p_dest0_i(p_dest0_i), .p_dest1_i(p_dest1_i),
        .old_dest0_i(old_dest0_i), .old_dest1_i(old_dest1_i),
        .rob_tag0_o(rob_tag0_o), .rob_tag1_o(rob_tag1_o),
        .rob_stall_o(rob_stall_o),
        .cmpl0_en_i(cmpl0_en_i), .cmpl1_en_i(cmpl1_en_i),
        .cmpl0_tag_i(cmpl0_tag_i), .cmpl1_tag_i(cmpl1_tag_i),
        .en_free_reg0_o(en_free_reg0_o), .en_free_reg1_o(en_free_reg1_o),
        .free_reg0_o(free_reg0_o), .free_reg1_o(free_reg1_o),
        .retire_cnt_o(retire_cnt_o), .rob_empty_o(rob_empty_o),
        .rob_count_o(rob_count_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] beat(input logic [1:0] cnt, input logic e0, input logic [5:0] f0,
                                          input logic e1, input logic [5:0] f1);
        return {cnt, e0, f0, e1, f1};
    endfunction

    // driver tasks
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic idle_inputs();
        alloc0_i = 0; alloc1_i = 0; cmpl0_en_i = 0; cmpl1_en_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1;
        tick(2);
        rst_i = 0;
        tick(1);
    endtask

    task automatic alloc(input logic two, input logic hd0, input logic [5:0] od0,
                         input logic hd1, input logic [5:0] od1);
        alloc0_i = 1; alloc1_i = two;
        has_dest0_i = hd0; old_dest0_i = od0; a_dest0_i = od0[4:0]; p_dest0_i = od0 + 6'd32;
        has_dest1_i = hd1; old_dest1_i = od1; a_dest1_i = od1[4:0]; p_dest1_i = od1 + 6'd32;
        tick(1);
        idle_inputs();
    endtask

    task automatic complete(input logic e0, input logic [3:0] t0, input logic e1, input logic [3:0] t1);
        cmpl0_en_i = e0; cmpl0_tag_i = t0; cmpl1_en_i = e1; cmpl1_tag_i = t1;
        tick(1);
        idle_inputs();
    endtask

    // scoreboard monitor
    always @(negedge clk_i) begin
        if (!rst_i && (retire_cnt_o != 2'd0 || en_free_reg0_o || en_free_reg1_o)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_retire", beat(retire_cnt_o, en_free_reg0_o, free_reg0_o,
                                                en_free_reg1_o, free_reg1_o), '0);
            end else begin
                check("retire_beat", beat(retire_cnt_o, en_free_reg0_o, free_reg0_o,
                                          en_free_reg1_o, free_reg1_o), exp_q.pop_front());
            end
        end
    end

    initial begin
        do_reset();

        // reset then idle
        check("rst_empty", W'(rob_empty_o), W'(1));
        check("rst_count", W'(rob_count_o), W'(0));
        check("rst_tag0", W'(rob_tag0_o), W'(0));
        check("rst_tag1", W'(rob_tag1_o), W'(1));
        check("rst_stall", W'(rob_stall_o), W'(0));
        check("rst_free", beat(retire_cnt_o, en_free_reg0_o, free_reg0_o, en_free_reg1_o, free_reg1_o), '0);

        // pair, younger completes first, then oldest releases both
        alloc(1, 1, 6'd5, 1, 6'd7);
        check("pair_count", W'(rob_count_o), W'(2));
        check("pair_tag0", W'(rob_tag0_o), W'(2));
        complete(1, 4'd1, 0, 4'd0);
        tick(2);
        check("pair_no_retire", W'(rob_count_o), W'(2));
        exp_q.push_back(beat(2'd2, 1, 6'd5, 1, 6'd7));
        complete(1, 4'd0, 0, 4'd0);
        tick(2);
        check("pair_drained", W'(rob_count_o), W'(0));

        // fill to 15, stall blocks further pairs; retire one frees stall next cycle
        for (int i = 0; i < 7; i++) alloc(1, 1, 6'(30 + 2 * i), 1, 6'(31 + 2 * i));
        check("fill14_stall", W'(rob_stall_o), W'(0));
        alloc(0, 1, 6'd50, 0, 6'd0);
        check("fill15_count", W'(rob_count_o), W'(15));
        check("fill15_stall", W'(rob_stall_o), W'(1));
        alloc(1, 1, 6'd51, 1, 6'd52);
        check("stalled_count", W'(rob_count_o), W'(15));
        check("stalled_tail", W'(rob_tag0_o), W'(1));
        exp_q.push_back(beat(2'd1, 1, 6'd30, 0, 6'd0));
        complete(1, 4'd2, 0, 4'd0);
        check("still_stalled", W'(rob_stall_o), W'(1));
        alloc(0, 1, 6'd53, 0, 6'd0);
        check("retire_cycle_count", W'(rob_count_o), W'(14));
        check("stall_cleared", W'(rob_stall_o), W'(0));
        tick(1);
        do_reset();

        // zero old_dest and no-dest entries retire without free strobes
        alloc(1, 1, 6'd0, 0, 6'd9);
        exp_q.push_back(beat(2'd2, 0, 6'd0, 0, 6'd0));
        complete(1, 4'd0, 1, 4'd1);
        tick(2);
        check("nofree_count", W'(rob_count_o), W'(0));

        // move tail to 15, then wrap with out-of-order completion
        for (int i = 0; i < 6; i++) alloc(1, 0, 6'd0, 0, 6'd0);
        alloc(0, 0, 6'd0, 0, 6'd0);
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(beat(2'd2, 0, 6'd0, 0, 6'd0));
            complete(1, 4'(2 + 2 * k), 1, 4'(3 + 2 * k));
        end
        exp_q.push_back(beat(2'd1, 0, 6'd0, 0, 6'd0));
        complete(1, 4'd14, 0, 4'd0);
        tick(2);
        check("wrap_pre_count", W'(rob_count_o), W'(0));
        check("wrap_tag0", W'(rob_tag0_o), W'(15));
        check("wrap_tag1", W'(rob_tag1_o), W'(0));
        alloc(1, 1, 6'd20, 1, 6'd21);
        complete(0, 4'd0, 1, 4'd0);
        tick(2);
        check("wrap_blocked", W'(rob_count_o), W'(2));
        exp_q.push_back(beat(2'd2, 1, 6'd20, 1, 6'd21));
        complete(1, 4'd15, 0, 4'd0);
        tick(2);
        check("wrap_count", W'(rob_count_o), W'(0));
        check("wrap_tail", W'(rob_tag0_o), W'(1));
        check("wrap_empty", W'(rob_empty_o), W'(1));

        // asynchronous reset mid-cycle with traffic in flight
        for (int i = 0; i < 3; i++) alloc(1, 1, 6'(40 + 2 * i), 1, 6'(41 + 2 * i));
        check("pre_rst_count", W'(rob_count_o), W'(6));
        complete(1, 4'd1, 1, 4'd2);
        alloc0_i = 1; alloc1_i = 1; cmpl0_en_i = 1; cmpl0_tag_i = 4'd3;
        #2;
        rst_i = 1;
        #1;
        check("async_count", W'(rob_count_o), W'(0));
        check("async_empty", W'(rob_empty_o), W'(1));
        check("async_tag0", W'(rob_tag0_o), W'(0));
        check("async_free", beat(retire_cnt_o, en_free_reg0_o, free_reg0_o, en_free_reg1_o, free_reg1_o), '0);
        tick(1);
        idle_inputs();
        rst_i = 0;
        tick(4);
        check("post_rst_count", W'(rob_count_o), W'(0));
        check("post_rst_tag1", W'(rob_tag1_o), W'(1));

        check("queue_drained", W'(exp_q.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
